m3_pwm_multich_gen: RTL and testbench
=====================================

Name: m3_pwm_multich_gen

Overview:
- Parametrised successor to the single-channel step PWM generator for the 3-phase motor drive.
- One shared period counter drives NCH independent duty channels, one per phase leg.
- Duty is shadow-latched at each period boundary. Period reload is forced by the commutation-step boundary (stepLast).
- Requests below the MOSFET minimum on-time are not truncated. They are accumulated across periods and emitted as minimum-width pulses, so average duty is preserved.
- Sits between the motor step sequencer (register block) and the gate-driver output mux.

Parameters:
- CW, 12, counter/duty width in bits (0xFFF × 0.1 µs at 10 MHz).
- NCH, 3, number of PWM channels.

Ports:
- clk  in  1  system clock, 10 MHz; all flops on rising edge.
- nRst  in  1  reset, asynchronous, active-low.
- en  in  1  run enable, synchronous.
- stepLast  in  1  one-cycle pulse on the last cycle of a commutation step; forces period reload.
- pwmPeriod  in  CW  period length in clk cycles; 0 = halt.
- pwmDuty  in  NCH*CW  per-channel requested on-cycles; channel i occupies bits [i*CW +: CW].
- pwmMinOn  in  CW  minimum on-pulse width; 0 disables min-on handling.
- pwm  out  NCH  registered PWM outputs.
- cycStart  out  1  registered pulse, high for the first cycle of each new period.
- accBusy  out  NCH  channel i accumulator nonzero (dither in progress).

Behaviour:
- Reset values: pwm = 0, cycStart = 0, accBusy = 0. Internal state resets to 0: period counter cnt, per-channel onCnt and acc, shadow registers.
- Idle condition: en = 0 or pwmPeriod = 0.
  - Next edge: cnt <= 0, all onCnt <= 0, pwm <= 0, acc <= 0, cycStart <= 0.
  - Idle takes priority over every other event.
- Reload event: R = !idle & (cnt == 0 | cnt == 1 | stepLast). stepLast coincident with cnt == 1 is a single reload, not two.
- On an R edge:
  - Latch P = pwmPeriod, M = pwmMinOn and per-channel duty.
  - cnt <= P; cycStart <= 1.
  - Per channel: onCnt <= g_i and pwm[i] <= (g_i != 0).
- Otherwise: cnt <= cnt − 1 (cnt ≥ 2 here); cycStart <= 0.
- Period length: P cycles between reloads absent stepLast. A stepLast reload truncates the current period; pwm is recomputed immediately at that edge.
- Latency: first period starts on the first edge after idle deasserts, so pwm is valid 1 cycle after en rises.
- Per-channel on-count, non-reload edges:
  - onCnt > 1: onCnt − 1, pwm holds 1.
  - onCnt == 1: onCnt <= 0, pwm <= 0.
  - onCnt == 0: pwm holds 0.
  - Net effect: pwm[i] is high for exactly g_i cycles from the reload edge, aligned to the period start.
- Grant g_i computation (combinational, at reload). d = min(duty_i, P). Width-extend to CW+1 bits for all sums.
  - d == 0: g = 0, acc <= 0.
  - M == 0, d ≥ M, or d == P: g = d, acc <= 0.
  - Otherwise, let s = acc + d:
    - s ≥ M: g = min(M, P), acc <= s − M.
    - s < M: g = 0, acc <= s.
  - acc is saturated at 2^CW − 1; it never wraps.
- Full-on: d == P gives continuous high across consecutive periods. No 1-cycle low gap is allowed at the reload edge.
- Period P = 1: reload every cycle; only g = 0 or g = 1 is possible.
- Shadowing: pwmDuty, pwmPeriod and pwmMinOn changes mid-period have no effect until the next R.
- accBusy[i] = (acc_i != 0), registered with acc.
- Reset mid-operation: all outputs go to 0 asynchronously. The first period after release behaves as after en rise.

Test Plan:
- Basic duty: en=1, P=100, duty=[30,50,0], M=0 → pwm0 high exactly 30 cycles, pwm1 50 cycles, pwm2 constant 0. cycStart pulses every 100 cycles.
- Min-on dither: P=100, M=32, duty0=8 → pwm0 emits a 32-cycle pulse once every 4 periods, nothing in the other 3. accBusy0 sequence is 1,1,1,0 with acc values 8,16,24,0.
- Clamp/full-on: P=50, duty0=0xFFF → pwm0 continuously high across 3+ periods with no gap. duty1=50 behaves identically.
- stepLast mid-period: P=200, duty0=150; assert stepLast at cnt=120 → pwm0 restarts with a fresh 150-cycle high from the next edge; cycStart pulses. Also assert stepLast coincident with cnt==1 → exactly one reload.
- Shadow update: change duty0 from 30 to 70 at cycle 10 of a 100-cycle period → current period stays 30-cycle high, next period is 70.
- Idle/reset: pwmPeriod=0 or en=0 mid-pulse → pwm=0 on the next edge, acc cleared. nRst low mid-period → all outputs 0 immediately. Restart on release gives first cycStart 1 cycle after en=1.

Source files
------------

// File: rtl/m3_pwm_multich_gen.sv
// m3_pwm_multich_gen
// Multi-channel PWM generator for the 3-phase motor drive.
// - One shared down-counting period counter serves NCH duty channels.
// - A commutation-step boundary (stepLast) forces an early period reload.
// - Requests shorter than the minimum on-time are accumulated across periods
//   and emitted as minimum-width pulses, so the average duty is preserved.
// Period, duty and min-on are sampled only at a reload edge; the captured
// values live on in cnt_q / on_cnt_q, so mid-period input changes are ignored.
module m3_pwm_multich_gen #(
  parameter int CW  = 12,
  parameter int NCH = 3
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              en,
  input  logic              stepLast,
  input  logic [CW-1:0]     pwmPeriod,
  input  logic [NCH*CW-1:0] pwmDuty,
  input  logic [CW-1:0]     pwmMinOn,
  output logic [NCH-1:0]    pwm,
  output logic              cycStart,
  output logic [NCH-1:0]    accBusy
);

  // Largest value the dither accumulator may hold; it saturates here
  // instead of wrapping.
  localparam logic [CW:0] ACC_MAX = {1'b0, {CW{1'b1}}};

  typedef struct packed {
    logic [CW-1:0] g;    // on-cycles granted for the coming period
    logic [CW-1:0] acc;  // accumulator value after this period
  } grant_t;

  // Clamp a CW+1 bit sum into the CW bit accumulator range.
  function automatic logic [CW-1:0] acc_sat(input logic [CW:0] x);
    return (x > ACC_MAX) ? ACC_MAX[CW-1:0] : x[CW-1:0];
  endfunction

  // Grant for one channel at a reload edge. All arithmetic is done one bit
  // wider than the operands so that acc + d can never overflow.
  function automatic grant_t calc_grant(
    input logic [CW-1:0] duty,
    input logic [CW-1:0] per,
    input logic [CW-1:0] min_on,
    input logic [CW-1:0] acc
  );
    grant_t      r;
    logic [CW:0] p;
    logic [CW:0] m;
    logic [CW:0] d;
    logic [CW:0] s;
    p     = {1'b0, per};
    m     = {1'b0, min_on};
    d     = ({1'b0, duty} < p) ? {1'b0, duty} : p;
    s     = {1'b0, acc} + d;
    r.g   = '0;
    r.acc = '0;
    if (d == '0) begin
      r.g   = '0;
      r.acc = '0;
    end else if ((m == '0) || (d >= m) || (d == p)) begin
      // Long enough on its own (or full-on): pass through, drop any dither.
      r.g   = d[CW-1:0];
      r.acc = '0;
    end else if (s >= m) begin
      // Enough accumulated: emit one minimum-width pulse, keep the remainder.
      r.g   = (m < p) ? m[CW-1:0] : p[CW-1:0];
      r.acc = acc_sat(s - m);
    end else begin
      // Still short: stay low this period and carry the request forward.
      r.g   = '0;
      r.acc = acc_sat(s);
    end
    return r;
  endfunction

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  on_cnt_q [NCH];
  logic [CW-1:0]  on_cnt_d [NCH];
  logic [CW-1:0]  acc_q    [NCH];
  logic [CW-1:0]  acc_d    [NCH];
  logic [NCH-1:0] pwm_q, pwm_d;
  logic [NCH-1:0] busy_q, busy_d;
  logic           cyc_q, cyc_d;
  grant_t         gr [NCH];
  logic           idle;
  logic           reload;

  assign idle   = !en || (pwmPeriod == '0);
  // stepLast landing on cnt == 1 is the same single reload, not a second one.
  assign reload = !idle && ((cnt_q == '0) || (cnt_q == CW'(1)) || stepLast);

  // Per-channel grant evaluated from the live inputs; used only on reload.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      gr[i] = calc_grant(pwmDuty[i*CW +: CW], pwmPeriod, pwmMinOn, acc_q[i]);
    end
  end

  // Next-state logic: idle clears everything, reload restarts the period,
  // otherwise the counters run down.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    cnt_d = cnt_q - CW'(1);
    cyc_d = 1'b0;
    pwm_d = pwm_q;
    for (int i = 0; i < NCH; i++) begin
      on_cnt_d[i] = on_cnt_q[i];
      acc_d[i]    = acc_q[i];
    end

    if (idle) begin
      cnt_d = '0;
      pwm_d = '0;
      for (int i = 0; i < NCH; i++) begin
        on_cnt_d[i] = '0;
        acc_d[i]    = '0;
      end
    end else if (reload) begin
      cnt_d = pwmPeriod;
      cyc_d = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        on_cnt_d[i] = gr[i].g;
        pwm_d[i]    = (gr[i].g != '0);
        acc_d[i]    = gr[i].acc;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (on_cnt_q[i] > CW'(1)) begin
          on_cnt_d[i] = on_cnt_q[i] - CW'(1);
        end else if (on_cnt_q[i] == CW'(1)) begin
          on_cnt_d[i] = '0;
          pwm_d[i]    = 1'b0;
        end
      end
    end

    for (int i = 0; i < NCH; i++) begin
      busy_d[i] = (acc_d[i] != '0);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nRst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    if (!nRst) begin
      cnt_q  <= '0;
      cyc_q  <= 1'b0;
      pwm_q  <= '0;
      busy_q <= '0;
      // NOTE: these per-channel arrays are control state, not storage, so
      // they are reset like any other flop.
      for (int i = 0; i < NCH; i++) begin
        on_cnt_q[i] <= '0;
        acc_q[i]    <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      cyc_q  <= cyc_d;
      pwm_q  <= pwm_d;
      busy_q <= busy_d;
      for (int i = 0; i < NCH; i++) begin
        on_cnt_q[i] <= on_cnt_d[i];
        acc_q[i]    <= acc_d[i];
      end
    end
  end

  assign pwm      = pwm_q;
  assign cycStart = cyc_q;
  assign accBusy  = busy_q;

endmodule

// File: tb/tb_m3_pwm_multich_gen.sv
// tb_m3_pwm_multich_gen
// Directed bench for m3_pwm_multich_gen (CW=12, NCH=3). Inputs change and
// outputs are sampled on the falling clock edge; expected values are
// hand-computed constants.
module tb_m3_pwm_multich_gen;

  logic        clk;
  logic        nRst;
  logic        en;
  logic        stepLast;
  logic [11:0] pwmPeriod;
  logic [35:0] pwmDuty;
  logic [11:0] pwmMinOn;
  logic [2:0]  pwm;
  logic        cycStart;
  logic [2:0]  accBusy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int hi0, hi1, hi2, cs_n;

  m3_pwm_multich_gen #(.CW(12), .NCH(3)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .en        (en),
    .stepLast  (stepLast),
    .pwmPeriod (pwmPeriod),
    .pwmDuty   (pwmDuty),
    .pwmMinOn  (pwmMinOn),
    .pwm       (pwm),
    .cycStart  (cycStart),
    .accBusy   (accBusy)
  );

  // 10 MHz clock.
  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sample the current cycle, then advance; repeated n times.
  task automatic measure(input int n);
    hi0 = 0; hi1 = 0; hi2 = 0; cs_n = 0;
    for (int k = 0; k < n; k++) begin
      if (pwm[0]) hi0++;
      if (pwm[1]) hi1++;
      if (pwm[2]) hi2++;
      if (cycStart) cs_n++;
      tick();
    end
  endtask

  task automatic set_cfg(input int p, input int m, input int d0, input int d1, input int d2);
    pwmPeriod = 12'(p);
    pwmMinOn  = 12'(m);
    pwmDuty   = {12'(d2), 12'(d1), 12'(d0)};
  endtask

  // Expected accBusy and pwm0 high-count for four min-on dither periods.
  logic [2:0] dith_busy [4] = '{3'b001, 3'b001, 3'b001, 3'b000};
  int         dith_hi   [4] = '{0, 0, 0, 32};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nRst = 1'b0; en = 1'b0; stepLast = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_pwm", 32'(pwm), 0);
    check("rst_cyc", 32'(cycStart), 0);
    check("rst_busy", 32'(accBusy), 0);
    nRst = 1'b1;
    tick();

    // Basic duty: P=100, duty=[30,50,0], M=0.
    set_cfg(100, 0, 30, 50, 0);
    en = 1'b1;
    tick();
    check("basic_first_cyc", 32'(cycStart), 1);
    check("basic_first_pwm", 32'(pwm), 32'(3'b011));
    measure(100);
    check("basic_hi0", hi0, 30);
    check("basic_hi1", hi1, 50);
    check("basic_hi2", hi2, 0);
    check("basic_cs", cs_n, 1);
    check("basic_next_cyc", 32'(cycStart), 1);

    // en=0 while pulses are high: everything low on the next edge.
    en = 1'b0;
    tick();
    check("en_off_pwm", 32'(pwm), 0);
    check("en_off_cyc", 32'(cycStart), 0);

    // Min-on dither: P=100, M=32, duty0=8 -> one 32-cycle pulse per 4 periods.
    set_cfg(100, 32, 8, 0, 0);
    en = 1'b1;
    tick();
    for (int p = 0; p < 4; p++) begin
      check($sformatf("dith_busy_%0d", p), 32'(accBusy), 32'(dith_busy[p]));
      measure(100);
      check($sformatf("dith_hi0_%0d", p), hi0, dith_hi[p]);
    end
    check("dith_busy_again", 32'(accBusy), 32'(3'b001));
    // pwmPeriod=0 halts and clears the accumulator.
    pwmPeriod = 12'd0;
    tick();
    check("halt_busy", 32'(accBusy), 0);
    check("halt_pwm", 32'(pwm), 0);

    // Clamp / full-on: P=50, duty=[0xFFF,50,25].
    set_cfg(50, 0, 12'hFFF, 50, 25);
    tick();
    measure(150);
    check("full_hi0", hi0, 150);
    check("full_hi1", hi1, 150);
    check("full_hi2", hi2, 75);
    check("full_cs", cs_n, 3);

    // P=1: reload every cycle, grant is 0 or 1.
    en = 1'b0;
    tick();
    set_cfg(1, 0, 1, 0, 5);
    en = 1'b1;
    tick();
    measure(10);
    check("p1_hi0", hi0, 10);
    check("p1_hi1", hi1, 0);
    check("p1_hi2", hi2, 10);
    check("p1_cs", cs_n, 10);

    // stepLast at cnt=120 of a 200-cycle period with duty0=150.
    en = 1'b0;
    tick();
    set_cfg(200, 0, 150, 0, 0);
    en = 1'b1;
    tick();
    measure(80);
    check("sl_pre_hi0", hi0, 80);
    stepLast = 1'b1;
    tick();
    stepLast = 1'b0;
    check("sl_mid_cyc", 32'(cycStart), 1);
    check("sl_mid_pwm", 32'(pwm), 32'(3'b001));
    measure(200);
    check("sl_mid_hi0", hi0, 150);
    check("sl_mid_cs", cs_n, 1);
    // stepLast coincident with cnt==1: still a single reload.
    measure(199);
    check("sl_end_pre_cyc", 32'(cycStart), 0);
    stepLast = 1'b1;
    tick();
    stepLast = 1'b0;
    check("sl_end_cyc", 32'(cycStart), 1);
    measure(200);
    check("sl_end_hi0", hi0, 150);
    check("sl_end_cs", cs_n, 1);

    // Shadowing: duty0 30 -> 70 at cycle 10 of the period.
    en = 1'b0;
    tick();
    set_cfg(100, 0, 30, 0, 0);
    en = 1'b1;
    tick();
    measure(10);
    set_cfg(100, 0, 70, 0, 0);
    measure(90);
    check("shadow_cur_hi0", hi0, 20);
    measure(100);
    check("shadow_next_hi0", hi0, 70);
    check("shadow_next_cyc", 32'(cycStart), 1);

    // Asynchronous reset mid-period, then restart on release.
    #10 nRst = 1'b0;
    #1;
    check("arst_pwm", 32'(pwm), 0);
    check("arst_cyc", 32'(cycStart), 0);
    check("arst_busy", 32'(accBusy), 0);
    @(negedge clk);
    nRst = 1'b1;
    tick();
    check("rel_cyc", 32'(cycStart), 1);
    check("rel_pwm", 32'(pwm), 32'(3'b001));
    measure(100);
    check("rel_hi0", hi0, 70);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
